// File: rtl/ei_reg_arbiter.sv
// Round-robin arbiter giving two requesters single-port access to the BLE setup register bank.
// Define EI_ARB_LOCK_EN to add m0_lock/m1_lock ports for atomic multi-register bursts.
module ei_reg_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 41,
    parameter int MEM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
`ifdef EI_ARB_LOCK_EN
    input  logic              m0_lock,
`endif
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
`ifdef EI_ARB_LOCK_EN
    input  logic              m1_lock,
`endif
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                rr_last_q, rr_last_d;
    logic                sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                bad_q, bad_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                m0_err_q, m0_err_d;
    logic                m1_err_q, m1_err_d;
    logic                req0, req1, win;
`ifdef EI_ARB_LOCK_EN
    logic                own_q, own_d;
    logic                own_port_q, own_port_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_last_q  <= 1'b1;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bad_q      <= 1'b0;
            cnt_q      <= '0;
            cap_q      <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
`ifdef EI_ARB_LOCK_EN
            own_q      <= 1'b0;
            own_port_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bad_q      <= bad_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
`ifdef EI_ARB_LOCK_EN
            own_q      <= own_d;
            own_port_q <= own_port_d;
`endif
        end
    end

    // Next-state and datapath
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        sel_d      = sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bad_d      = bad_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_err_d   = m0_err_q;
        m1_err_d   = m1_err_q;
        req0       = m0_req;
        req1       = m1_req;
        win        = 1'b0;
`ifdef EI_ARB_LOCK_EN
        own_d      = own_q;
        own_port_d = own_port_q;
`endif

        unique case (state_q)
            S_IDLE: begin
`ifdef EI_ARB_LOCK_EN
                // A locked owner masks the other port; its own lock=0 releases ownership.
                if (own_q) begin
                    if (own_port_q ? m1_lock : m0_lock) begin
                        if (own_port_q) req0 = 1'b0;
                        else            req1 = 1'b0;
                    end else begin
                        own_d = 1'b0;
                    end
                end
`endif
                win = (req0 && req1) ? ~rr_last_q : req1;
                if (req0 || req1) begin
                    sel_d     = win;
                    rr_last_d = win;
                    we_d      = win ? m1_we    : m0_we;
                    addr_d    = win ? m1_addr  : m0_addr;
                    wdata_d   = win ? m1_wdata : m0_wdata;
                    bad_d     = (int'(win ? m1_addr : m0_addr) >= NUM_REGS);
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cap_d   = '0;
                cnt_d   = '0;
                state_d = bad_q ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
                    cap_d   = we_q ? '0 : mem_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (sel_q) begin
                    m1_rdata_d = cap_q;
                    m1_err_d   = bad_q;
                end else begin
                    m0_rdata_d = cap_q;
                    m0_err_d   = bad_q;
                end
`ifdef EI_ARB_LOCK_EN
                own_d      = sel_q ? m1_lock : m0_lock;
                own_port_d = sel_q;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: strobes decode from state; response data bypasses the hold register in RESP
    always_comb begin
        m0_gnt    = (state_q == S_ISSUE) && !sel_q;
        m1_gnt    = (state_q == S_ISSUE) &&  sel_q;
        mem_en    = (state_q == S_ISSUE) && !bad_q;
        mem_we    = mem_en && we_q;
        mem_addr  = mem_en ? addr_q  : '0;
        mem_wdata = mem_en ? wdata_q : '0;
        m0_rvalid = (state_q == S_RESP) && !sel_q;
        m1_rvalid = (state_q == S_RESP) &&  sel_q;
        m0_rdata  = m0_rvalid ? cap_q : m0_rdata_q;
        m1_rdata  = m1_rvalid ? cap_q : m1_rdata_q;
        m0_err    = m0_rvalid ? bad_q : m0_err_q;
        m1_err    = m1_rvalid ? bad_q : m1_err_q;
    end

endmodule

// File: doc/ei_reg_arbiter.md
Name: ei_reg_arbiter

Overview:
Arbitrates single-port access to the BLE setup register bank (41 byte-wide registers, indices 0..40, EIR_TEST..EIR_ERROR) between two requesters:
- Port 0: host command decoder.
- Port 1: BLE setup sequencer.

Round-robin grant, one transaction in flight, address range checking, a response pulse per transaction. Sits between the requesters and the register-bank RAM.

Parameters:
ADDR_W, 6, register address width (matches ei_regs_t)
DATA_W, 8, register data width
NUM_REGS, 41, valid addresses are 0..NUM_REGS-1
MEM_LAT, 1, RAM read latency in cycles (1..3)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m0_req  in  1  port 0 request; held with command until m0_gnt
m0_we  in  1  port 0 write (1) / read (0)
m0_addr  in  ADDR_W  port 0 register address
m0_wdata  in  DATA_W  port 0 write data
m0_gnt  out  1  port 0 command accepted (1-cycle pulse)
m0_rvalid  out  1  port 0 response (1-cycle pulse)
m0_rdata  out  DATA_W  port 0 read data, valid with m0_rvalid
m0_err  out  1  port 0 address error, valid with m0_rvalid
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err  (port 1; directions, widths and meanings as port 0)
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, MEM_LAT cycles after mem_en

Behaviour:
- Reset: one clock, synchronous active-high reset. All outputs 0; state IDLE; rr_last=1, so port 0 wins the first tie. Reset mid-transaction aborts it: no gnt/rvalid is emitted afterwards, and mem_en drops in the next cycle.
- IDLE:
  - Sample requests.
  - One requester: pick it.
  - Both requesting: pick the port != rr_last.
  - Latch the winner's we/addr/wdata, set rr_last=winner, go to ISSUE.
- ISSUE (1 cycle):
  - Pulse mX_gnt.
  - addr < NUM_REGS: drive mem_en=1 with mem_we/mem_addr/mem_wdata from the latch; go to WAIT.
  - addr >= NUM_REGS: no RAM access (mem_en=0); set err flag; go to RESP.
- WAIT:
  - Count MEM_LAT cycles after the mem_en cycle.
  - Capture mem_rdata on the last count for reads.
  - Go to RESP.
- RESP (1 cycle):
  - Pulse mX_rvalid for the granted port only.
  - rdata = captured data for a read; 0 for a write or error.
  - err = flag.
  - Return to IDLE.
- rdata/err hold their value between rvalid pulses. Only the granted port's rdata/err update.
- Latency, req sampled at cycle T:
  - gnt at T+1.
  - mem_en at T+1.
  - rvalid at T+2+MEM_LAT for a valid address.
  - rvalid at T+2 for an invalid address.
- Requester rules:
  - A requester deasserts req the cycle after gnt, or keeps it high to queue the next command.
  - req is ignored outside IDLE.
  - req dropping before gnt is legal (request withdrawn). A withdrawn request is not granted unless it is still asserted in the IDLE sample cycle.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1,…
- mem_* outputs are 0 whenever mem_en=0.

Optional Feature:
Macro EI_ARB_LOCK_EN adds inputs m0_lock and m1_lock (1 bit each).
- With the macro:
  - If the granted port has lock=1 when its RESP completes, that port keeps ownership.
  - In IDLE only the owner's req is considered, regardless of rr_last. This gives atomic bursts, e.g. DVC_NAME0..7.
  - Ownership is released when the owner's lock=0 is sampled in IDLE, or on reset.
- Without the macro: no lock ports; pure round-robin.

Test Plan:
- Reset, then m0 write addr 3 data 8'hA5, then m0 read addr 3 -> gnt at T+1; mem_en/we=1, addr=3 at T+1; read rvalid at T+3 (MEM_LAT=1) with m0_rdata=8'hA5, m0_err=0.
- m1 read addr 41 (invalid) -> m1_gnt at T+1; mem_en never asserted; m1_rvalid at T+2 with err=1, rdata=0.
- m0 and m1 requesting continuously from reset -> grant order 0,1,0,1; each rvalid goes to the matching port only.
- MEM_LAT=3, m1 read addr 40 preloaded 8'h3C -> m1_rvalid at T+5, rdata=8'h3C.
- Assert rst during WAIT of an m0 read -> no m0_rvalid follows; all outputs 0 the next cycle; the next request is granted normally.
- EI_ARB_LOCK_EN: m1 holds lock=1 and writes addrs 13..20 while m0 requests -> all 8 m1 grants are consecutive; m0 is granted only after m1 lock=0.
